// File: rtl/exec_trace_buffer.sv
// Triggerable execution-trace buffer: captures PC/instruction/ALU result per retired
// instruction into a circular store, then drains it oldest-first over a valid/ready port.
module exec_trace_buffer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [ADDR_W-1:0]        trig_pc,
  input  logic                     cap_valid,
  input  logic [ADDR_W-1:0]        cap_pc,
  input  logic [DATA_W-1:0]        cap_instr,
  input  logic [DATA_W-1:0]        cap_result,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_result,
  output logic [TS_W-1:0]          rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [TS_W-1:0]  stamp_q, stamp_d;

  logic             we;
  logic [TS_W-1:0]  we_stamp;

  logic [ADDR_W-1:0] mem_pc     [DEPTH];
  logic [DATA_W-1:0] mem_instr  [DEPTH];
  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [TS_W-1:0]   mem_stamp  [DEPTH];

  logic trig_hit;
  logic full;
  logic pop;

  assign trig_hit = cap_valid && (!trig_en || (cap_pc == trig_pc));
  assign full     = (count_q == CNT_W'(DEPTH));
  assign rd_valid = (state_q == StDone) && (count_q != '0);
  assign pop      = rd_valid && rd_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    stamp_d    = stamp_q;
    we         = 1'b0;
    we_stamp   = stamp_q;

    unique case (state_q)
      StIdle: ;
      StArmed: begin
        if (trig_hit) begin
          // Triggering sample is entry 0; the next clock is one tick after the trigger.
          we       = 1'b1;
          we_stamp = '0;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
          stamp_d  = TS_W'(1);
          state_d  = stop ? StDone : StCapture;
        end else if (stop) begin
          state_d = StIdle;
        end
      end
      StCapture: begin
        stamp_d = stamp_q + TS_W'(1);
        if (cap_valid && !(full && !mode)) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (full) begin
            // WRAP: overwrite the oldest entry and drag the read pointer along.
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
          if (!mode && (count_q == CNT_W'(DEPTH - 1))) state_d = StDone;
        end
        if (stop) state_d = StDone;
      end
      StDone: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (arm) begin
      state_d    = StArmed;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      stamp_d    = '0;
      we         = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      stamp_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stamp_q    <= stamp_d;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_pc[wr_ptr_q]     <= cap_pc;
      mem_instr[wr_ptr_q]  <= cap_instr;
      mem_result[wr_ptr_q] <= cap_result;
      mem_stamp[wr_ptr_q]  <= we_stamp;
    end
  end

  always_comb begin
    rd_pc     = '0;
    rd_instr  = '0;
    rd_result = '0;
    rd_stamp  = '0;
    if (rd_valid) begin
      rd_pc     = mem_pc[rd_ptr_q];
      rd_instr  = mem_instr[rd_ptr_q];
      rd_result = mem_result[rd_ptr_q];
      rd_stamp  = mem_stamp[rd_ptr_q];
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Scoreboard bench for exec_trace_buffer: expected entries are queued as samples are
// driven and compared as the DUT drains them.
module tb_exec_trace_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [15:0] stamp;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        arm, stop, mode, trig_en, cap_valid, rd_ready;
  logic [31:0] trig_pc, cap_pc, cap_instr, cap_result;
  logic        rd_valid, overflow;
  logic [31:0] rd_pc, rd_instr, rd_result;
  logic [15:0] rd_stamp;
  logic [4:0]  count;
  logic [1:0]  state;

  // Small instance for timestamp wrap.
  logic        s_arm, s_stop, s_cap_valid, s_rd_ready;
  logic [7:0]  s_cap_pc;
  logic        s_rd_valid, s_overflow;
  logic [7:0]  s_rd_pc, s_rd_instr, s_rd_result;
  logic [3:0]  s_rd_stamp;
  logic [2:0]  s_count;
  logic [1:0]  s_state;

  int     n_checks = 0;
  int     n_fail   = 0;
  entry_t exp_q[$];

  exec_trace_buffer dut (
    .clock(clock), .reset_n(reset_n), .arm(arm), .stop(stop), .mode(mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .cap_result(cap_result), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_result(rd_result),
    .rd_stamp(rd_stamp), .count(count), .overflow(overflow), .state(state)
  );

  exec_trace_buffer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .TS_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .arm(s_arm), .stop(s_stop), .mode(1'b0),
    .trig_en(1'b0), .trig_pc(8'h00), .cap_valid(s_cap_valid), .cap_pc(s_cap_pc),
    .cap_instr(s_cap_pc), .cap_result(s_cap_pc), .rd_ready(s_rd_ready),
    .rd_valid(s_rd_valid), .rd_pc(s_rd_pc), .rd_instr(s_rd_instr),
    .rd_result(s_rd_result), .rd_stamp(s_rd_stamp), .count(s_count),
    .overflow(s_overflow), .state(s_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  function automatic logic [31:0] result_of(input logic [31:0] pc);
    return pc * 3 + 32'd7;
  endfunction

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    cap_valid  = v;
    cap_pc     = pc;
    cap_instr  = instr_of(pc);
    cap_result = result_of(pc);
  endtask

  task automatic expect_entry(input logic [31:0] pc, input int stamp);
    entry_t e;
    e.pc     = pc;
    e.instr  = instr_of(pc);
    e.result = result_of(pc);
    e.stamp  = 16'(stamp);
    exp_q.push_back(e);
  endtask

  task automatic drain(input bit toggle);
    int          guard = 0;
    bit          rdy = 1'b1;
    bit          was_held;
    logic [31:0] held_pc;
    logic [15:0] held_stamp;
    entry_t      e;
    while (exp_q.size() > 0 && guard < 200) begin
      rd_ready = toggle ? rdy : 1'b1;
      was_held = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          e = exp_q.pop_front();
          check("rd_pc", 64'(rd_pc), 64'(e.pc));
          check("rd_instr", 64'(rd_instr), 64'(e.instr));
          check("rd_result", 64'(rd_result), 64'(e.result));
          check("rd_stamp", 64'(rd_stamp), 64'(e.stamp));
        end else begin
          was_held   = 1'b1;
          held_pc    = rd_pc;
          held_stamp = rd_stamp;
        end
      end
      tick();
      if (was_held) begin
        check("hold_pc", 64'(rd_pc), 64'(held_pc));
        check("hold_stamp", 64'(rd_stamp), 64'(held_stamp));
      end
      rdy = !rdy;
      guard++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    rd_ready = 1'b0;
    check("drain_count", 64'(count), 64'd0);
    check("drain_state", 64'(state), 64'd0);
    check("drain_valid", 64'(rd_valid), 64'd0);
    check("drain_zero_pc", 64'(rd_pc), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    {arm, stop, mode, trig_en, cap_valid, rd_ready} = '0;
    trig_pc = '0;
    drive(1'b0, 32'h0);
    {s_arm, s_stop, s_cap_valid, s_rd_ready} = '0;
    s_cap_pc = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_pc", 64'(rd_pc), 64'd0);

    // Reset in the middle of a capture.
    trig_en = 1'b0;
    pulse_arm();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 32'h0);
    check("mid_count", 64'(count), 64'd5);
    check("mid_state", 64'(state), 64'd2);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    check("rr_state", 64'(state), 64'd0);
    check("rr_count", 64'(count), 64'd0);
    check("rr_valid", 64'(rd_valid), 64'd0);
    check("rr_ovf", 64'(overflow), 64'd0);

    // STOP_FULL with PC trigger at 0x10.
    mode    = 1'b0;
    trig_en = 1'b1;
    trig_pc = 32'h10;
    pulse_arm();
    check("armed_state", 64'(state), 64'd1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(4 * i));
      if (i >= 4) expect_entry(32'(4 * i), i - 4);
      tick();
    end
    drive(1'b0, 32'h0);
    check("full_state", 64'(state), 64'd3);
    check("full_count", 64'(count), 64'd16);
    check("full_ovf", 64'(overflow), 64'd0);
    drain(1'b0);

    // WRAP, trigger on first sample, 20 samples then stop.
    mode    = 1'b1;
    trig_en = 1'b0;
    pulse_arm();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      if (i >= 4) expect_entry(32'h100 + 32'(4 * i), i);
      tick();
    end
    drive(1'b0, 32'h0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("wrap_state", 64'(state), 64'd3);
    check("wrap_count", 64'(count), 64'd16);
    check("wrap_ovf", 64'(overflow), 64'd1);
    drain(1'b0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Sparse capture, drained with backpressure.
    mode = 1'b0;
    pulse_arm();
    check("arm_clr_ovf", 64'(overflow), 64'd0);
    for (int t = 0; t < 10; t++) begin
      drive(t % 3 == 0, 32'h300 + 32'(t));
      if (t % 3 == 0) expect_entry(32'h300 + 32'(t), t);
      tick();
    end
    drive(1'b0, 32'h0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sparse_count", 64'(count), 64'd4);
    drain(1'b1);

    // arm together with stop during capture.
    pulse_arm();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 32'h0);
    arm  = 1'b1;
    stop = 1'b1;
    tick();
    arm  = 1'b0;
    stop = 1'b0;
    check("armstop_state", 64'(state), 64'd1);
    check("armstop_count", 64'(count), 64'd0);

    // stop together with cap_valid stores that sample.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i));
      expect_entry(32'h500 + 32'(4 * i), i);
      stop = (i == 2);
      tick();
    end
    stop = 1'b0;
    drive(1'b0, 32'h0);
    check("stopcap_state", 64'(state), 64'd3);
    check("stopcap_count", 64'(count), 64'd3);
    drain(1'b0);

    // Timestamp wraps modulo 2^4 on the small instance.
    s_arm = 1'b1;
    tick();
    s_arm       = 1'b0;
    s_cap_valid = 1'b1;
    s_cap_pc    = 8'h40;
    tick();
    s_cap_valid = 1'b0;
    repeat (16) tick();
    s_cap_valid = 1'b1;
    s_cap_pc    = 8'h44;
    s_stop      = 1'b1;
    tick();
    s_cap_valid = 1'b0;
    s_stop      = 1'b0;
    check("ts4_state", 64'(s_state), 64'd3);
    check("ts4_count", 64'(s_count), 64'd2);
    check("ts4_stamp0", 64'(s_rd_stamp), 64'd0);
    s_rd_ready = 1'b1;
    tick();
    check("ts4_pc1", 64'(s_rd_pc), 64'h44);
    check("ts4_stamp1", 64'(s_rd_stamp), 64'd1);
    tick();
    s_rd_ready = 1'b0;
    check("ts4_idle", 64'(s_state), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_trace_buffer.md
# exec_trace_buffer

Parametrised execution-trace capture unit for the single-cycle processor. It takes the place of free-running console monitoring with a synthesizable, triggerable trace buffer. Each cycle it samples the retired instruction's PC, instruction word and ALU result into a DEPTH-entry circular buffer, starting capture on a PC match. Captured entries are then drained through a valid/ready read port in oldest-first order.

## Interface
- ADDR_W, 32, PC width
- DATA_W, 32, instruction and ALU result width
- DEPTH, 16, buffer entries; power of two, at least 2
- TS_W, 16, timestamp width
- clock  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle pulse: clear buffer and wait for trigger
- stop  in  1  single-cycle pulse: end capture
- mode  in  1  0 = STOP_FULL (halt when full), 1 = WRAP (overwrite oldest)
- trig_en  in  1  1 = trigger on PC match, 0 = trigger on first valid sample
- trig_pc  in  ADDR_W  trigger PC value
- cap_valid  in  1  current cycle holds a retired instruction
- cap_pc  in  ADDR_W  PC of the retired instruction
- cap_instr  in  DATA_W  instruction word
- cap_result  in  DATA_W  ALU result
- rd_ready  in  1  consumer accepts the read entry
- rd_valid  out  1  read entry valid
- rd_pc  out  ADDR_W  oldest entry PC
- rd_instr  out  DATA_W  oldest entry instruction
- rd_result  out  DATA_W  oldest entry ALU result
- rd_stamp  out  TS_W  cycles from trigger to this entry
- count  out  clog2(DEPTH)+1  entries held
- overflow  out  1  at least one entry was overwritten in WRAP mode
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE

## Operation
- Storage: DEPTH x (ADDR_W+2*DATA_W+TS_W) register array, write pointer wr_ptr, read pointer rd_ptr. Pointers wrap modulo DEPTH.
- IDLE: ignores cap_*. A pulse on arm clears pointers, count and overflow, then goes to ARMED.
- ARMED: the trigger fires when cap_valid is high and either trig_en=0 or cap_pc==trig_pc.
  - The triggering sample is written as entry 0 with stamp 0, and the state goes to CAPTURE.
  - stop with no trigger returns to IDLE.
- CAPTURE: the stamp counter increments every clock and wraps modulo 2^TS_W. Each cap_valid writes one entry at wr_ptr with the current stamp.
- STOP_FULL mode: the write that makes count==DEPTH also moves the state to DONE. No further writes occur.
- WRAP mode, buffer full: a write overwrites the oldest entry, advances rd_ptr with wr_ptr, holds count at DEPTH and sets overflow.
- stop in CAPTURE moves the state to DONE. If cap_valid is high in the same cycle, that sample is written first.
- DONE: rd_valid = (count != 0). rd_* show the entry at rd_ptr combinationally.
  - When rd_valid and rd_ready are both high, rd_ptr increments and count decrements.
  - The pop that empties the buffer returns the state to IDLE.
  - A DONE state with count 0 cannot occur.
- rd_* outputs are driven to 0 whenever rd_valid is low.
- arm has priority over every other event in every state. It restarts from ARMED and discards held data.
- overflow stays set until the next arm or reset.

## Timing
- Reset (asynchronous assert, synchronous deassert at the system level) sets:
  - state = IDLE, count = 0, overflow = 0, rd_valid = 0, all rd_* = 0
  - pointers and stamp counter = 0
  - buffer contents are don't-care
- Write latency: a sample valid at edge N is reflected in count after edge N.
- In DONE it is readable when rd_ptr reaches it.
- The state goes to DONE on the edge that performs the filling write or accepts stop. rd_valid goes high in the first cycle after that edge.
- Read throughput: one entry per cycle while rd_ready is held high. rd_* update in the cycle after each accepted pop.
- cap_* are ignored in IDLE and DONE.
- The trigger compare is combinational on the same-cycle cap_pc, so there is no trigger latency.
- Stamp semantics: an entry captured k clocks after the trigger edge has stamp k mod 2^TS_W, whether or not cap_valid was high in between.

## Test plan
- Reset mid-CAPTURE with 5 entries held, then release -> state=0, count=0, rd_valid=0, overflow=0 on the next clock.
- STOP_FULL, trig_en=1, trig_pc=0x10; stream PCs 0x00,0x04,...,0x4C with cap_valid high every cycle:
  - capture starts at 0x10, and DONE is reached after 16 entries
  - the drain yields PCs 0x10..0x4C with stamps 0..15
  - count returns to 0 and the state to IDLE
- WRAP, trig_en=0; 20 valid samples, then stop:
  - count=16 and overflow=1
  - the first drained entry is the 5th sample with stamp 4, the last is stamp 19
- Sparse capture: cap_valid every 3rd cycle, stop after 4 entries -> stamps 0,3,6,9 and count=4.
- Readout backpressure: rd_ready toggles 1,0,1,0 -> the entry is held stable while rd_ready=0, and each entry is popped exactly once.
- Simultaneous events:
  - arm together with stop in CAPTURE -> ARMED, count=0
  - stop together with cap_valid -> that sample is stored and the state goes to DONE
  - TS_W=4 with a trigger followed by a sample 17 cycles later -> rd_stamp=1
